// File: rtl/fp_norm_pkg.sv
// Shared types and default widths for the floating-point mantissa normalizer.
package fp_norm_pkg;

  localparam int unsigned DEF_MANT_W = 279;
  localparam int unsigned DEF_EXP_W  = 8;
  localparam int unsigned DEF_STEP   = 8;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    OP_DONE,
    OP_COARSE,
    OP_SINGLE,
    OP_UFLOW
  } step_op_e;

endpackage

// File: rtl/fp_norm_step.sv
// One normalization step: picks done / coarse shift / single shift / underflow
// from the current working registers and produces the next mantissa and exponent.
module fp_norm_step
  import fp_norm_pkg::*;
#(
  parameter int unsigned MANT_W = DEF_MANT_W,
  parameter int unsigned EXP_W  = DEF_EXP_W,
  parameter int unsigned STEP   = DEF_STEP
) (
  input  logic [MANT_W-1:0] mant_cur,
  input  logic [EXP_W-1:0]  exp_cur,
  output logic [MANT_W-1:0] mant_nxt,
  output logic [EXP_W-1:0]  exp_nxt,
  output step_op_e          op
);

  localparam logic [EXP_W-1:0] STEP_EXP = EXP_W'(STEP);
  localparam logic [EXP_W-1:0] ONE_EXP  = EXP_W'(1);

  logic top_zero;
  assign top_zero = (mant_cur[MANT_W-1 -: STEP] == '0);

  // Strict '>' on both shift paths keeps the exponent at or above 1.
  always_comb begin
    op       = OP_DONE;
    mant_nxt = mant_cur;
    exp_nxt  = exp_cur;
    if (mant_cur[MANT_W-1]) begin
      op = OP_DONE;
    end else if (top_zero && (exp_cur > STEP_EXP)) begin
      op       = OP_COARSE;
      mant_nxt = mant_cur << STEP;
      exp_nxt  = exp_cur - STEP_EXP;
    end else if (exp_cur > ONE_EXP) begin
      op       = OP_SINGLE;
      mant_nxt = mant_cur << 1;
      exp_nxt  = exp_cur - ONE_EXP;
    end else begin
      op = OP_UFLOW;
    end
  end

endmodule

// File: rtl/fp_norm_sequencer.sv
// Iterative mantissa normalizer: accepts an operand, shifts it left until the MSB
// is set or the exponent bottoms out, then holds the result until consumed.
module fp_norm_sequencer
  import fp_norm_pkg::*;
#(
  parameter int unsigned MANT_W = DEF_MANT_W,
  parameter int unsigned EXP_W  = DEF_EXP_W,
  parameter int unsigned STEP   = DEF_STEP
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [EXP_W-1:0]  exp_in,
  input  logic [MANT_W-1:0] mant_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [EXP_W-1:0]  exp_out,
  output logic [MANT_W-1:0] mant_out,
  output logic              zero,
  output logic              underflow,
  output logic              busy
);

  state_e            state_q, state_d;
  logic [EXP_W-1:0]  exp_q, exp_d;
  logic [MANT_W-1:0] mant_q, mant_d;
  logic              zero_q, zero_d;
  logic              underflow_q, underflow_d;

  logic [MANT_W-1:0] step_mant;
  logic [EXP_W-1:0]  step_exp;
  step_op_e          step_op;

  fp_norm_step #(
    .MANT_W (MANT_W),
    .EXP_W  (EXP_W),
    .STEP   (STEP)
  ) u_step (
    .mant_cur (mant_q),
    .exp_cur  (exp_q),
    .mant_nxt (step_mant),
    .exp_nxt  (step_exp),
    .op       (step_op)
  );

  always_comb begin
    state_d     = state_q;
    exp_d       = exp_q;
    mant_d      = mant_q;
    zero_d      = zero_q;
    underflow_d = underflow_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          exp_d       = exp_in;
          mant_d      = mant_in;
          zero_d      = 1'b0;
          underflow_d = 1'b0;
          if (mant_in == '0) begin
            state_d = DONE;
            zero_d  = 1'b1;
            exp_d   = '0;
          end else if (mant_in[MANT_W-1]) begin
            state_d = DONE;
          end else if (exp_in <= EXP_W'(1)) begin
            state_d     = DONE;
            underflow_d = 1'b1;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        mant_d = step_mant;
        exp_d  = step_exp;
        case (step_op)
          OP_DONE:  state_d = DONE;
          OP_UFLOW: begin
            state_d     = DONE;
            underflow_d = 1'b1;
          end
          default:  state_d = SHIFT;
        endcase
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      exp_q       <= '0;
      mant_q      <= '0;
      zero_q      <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      exp_q       <= exp_d;
      mant_q      <= mant_d;
      zero_q      <= zero_d;
      underflow_q <= underflow_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == SHIFT);
  assign exp_out   = exp_q;
  assign mant_out  = mant_q;
  assign zero      = zero_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_fp_norm_sequencer.sv
// Directed bench for fp_norm_sequencer with a scoreboard of expected results
// computed from a leading-zero-count model.
module tb_fp_norm_sequencer;

  localparam int MANT_W = 279;
  localparam int EXP_W  = 8;
  localparam int STEP   = 8;

  typedef struct {
    logic [EXP_W-1:0]  exp_v;
    logic [MANT_W-1:0] mant_v;
    logic              zero_v;
    logic              uflow_v;
    int                lat;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [EXP_W-1:0]  exp_in;
  logic [MANT_W-1:0] mant_in;
  logic              out_valid;
  logic              out_ready;
  logic [EXP_W-1:0]  exp_out;
  logic [MANT_W-1:0] mant_out;
  logic              zero;
  logic              underflow;
  logic              busy;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  fp_norm_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .exp_in    (exp_in),
    .mant_in   (mant_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .exp_out   (exp_out),
    .mant_out  (mant_out),
    .zero      (zero),
    .underflow (underflow),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [MANT_W-1:0] obs,
                       input logic [MANT_W-1:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Model works on (leading zeros, exponent) rather than the mantissa bits.
  function automatic exp_t model(input logic [EXP_W-1:0] e, input logic [MANT_W-1:0] m);
    exp_t r;
    int lz = 0;
    int ev = int'(e);
    int sh = 0;
    int ops = 0;
    r.zero_v  = 1'b0;
    r.uflow_v = 1'b0;
    r.exp_v   = e;
    r.mant_v  = m;
    r.lat     = 1;
    if (m == '0) begin
      r.zero_v = 1'b1;
      r.exp_v  = '0;
      return r;
    end
    while (lz < MANT_W && !m[MANT_W-1-lz]) lz++;
    if (lz == 0) return r;
    if (ev <= 1) begin
      r.uflow_v = 1'b1;
      return r;
    end
    while (lz > 0) begin
      if (lz >= STEP && ev > STEP) begin
        lz -= STEP; ev -= STEP; sh += STEP; ops++;
      end else if (ev > 1) begin
        lz--; ev--; sh++; ops++;
      end else begin
        r.uflow_v = 1'b1;
        break;
      end
    end
    r.lat    = ops + 2;
    r.exp_v  = EXP_W'(ev);
    r.mant_v = m << sh;
    return r;
  endfunction

  function automatic logic [MANT_W-1:0] mk_mant(input int lz, input bit rnd);
    logic [MANT_W-1:0] m = '0;
    if (rnd) for (int i = 0; i < 9; i++) m = {m[MANT_W-33:0], 32'($urandom())};
    m = m >> lz;
    m[MANT_W-1-lz] = 1'b1;
    return m;
  endfunction

  // Offer one operand, wait for the result, optionally stall the consumer.
  task automatic run_op(input logic [EXP_W-1:0] e, input logic [MANT_W-1:0] m,
                        input int hold, output int lat);
    exp_t x;
    exp_t cur;
    x = model(e, m);
    sb.push_back(x);
    @(negedge clk);
    in_valid = 1'b1;
    exp_in   = e;
    mant_in  = m;
    check("in_ready before accept", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    if (x.lat > 1) begin
      check("busy in shift", busy, 1);
      check("in_ready low in shift", in_ready, 0);
    end
    while (!out_valid && lat < 600) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) begin
      check("out_valid timeout", out_valid, 1);
      $display("FAIL fatal: no result within cycle budget");
      $fatal(1);
    end
    cur = sb.pop_front();
    check("latency", lat, cur.lat);
    check("exp_out", exp_out, cur.exp_v);
    check("mant_out", mant_out, cur.mant_v);
    check("zero", zero, cur.zero_v);
    check("underflow", underflow, cur.uflow_v);
    check("in_ready in done", in_ready, 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      exp_in   = 8'd7;
      mant_in  = mk_mant(3, 1'b1);
      @(posedge clk); #1;
      check("hold out_valid", out_valid, 1);
      check("hold in_ready", in_ready, 0);
      check("hold exp_out", exp_out, cur.exp_v);
      check("hold mant_out", mant_out, cur.mant_v);
      check("hold flags", {zero, underflow}, {cur.zero_v, cur.uflow_v});
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("release out_valid", out_valid, 0);
    check("release in_ready", in_ready, 1);
    check("release busy", busy, 0);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    logic [MANT_W-1:0] m;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    exp_in    = '0;
    mant_in   = '0;
    #1;
    check("reset in_ready", in_ready, 1);
    check("reset out_valid", out_valid, 0);
    check("reset busy", busy, 0);
    check("reset flags", {zero, underflow}, 0);
    check("reset exp_out", exp_out, 0);
    check("reset mant_out", mant_out, 0);
    @(negedge clk);
    reset = 1'b0;

    run_op(8'd100, mk_mant(0, 1'b1), 0, lat);
    check("msb-set latency literal", lat, 1);
    m = mk_mant(20, 1'b1);
    run_op(8'd100, m, 0, lat);
    check("20lz latency literal", lat, 8);
    check("20lz exp literal", exp_out, 80);
    check("20lz msb", mant_out[MANT_W-1], 1);
    run_op(8'd55, '0, 0, lat);
    check("zero exp literal", exp_out, 0);
    run_op(8'd3, mk_mant(10, 1'b1), 0, lat);
    check("uflow latency literal", lat, 4);
    check("uflow exp literal", exp_out, 1);
    check("uflow msb still 0", mant_out[MANT_W-1], 0);
    run_op(8'd1, mk_mant(5, 1'b0), 0, lat);
    run_op(8'd9, mk_mant(8, 1'b1), 0, lat);
    run_op(8'd250, mk_mant(270, 1'b1), 0, lat);
    run_op(8'd100, mk_mant(20, 1'b1), 5, lat);

    // Reset in the middle of a long shift sequence discards the operation.
    sb.push_back(model(8'd250, mk_mant(200, 1'b0)));
    @(negedge clk);
    in_valid = 1'b1;
    exp_in   = 8'd250;
    mant_in  = mk_mant(200, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("busy before reset", busy, 1);
    reset = 1'b1;
    #1;
    void'(sb.pop_front());
    check("mid-reset in_ready", in_ready, 1);
    check("mid-reset out_valid", out_valid, 0);
    check("mid-reset busy", busy, 0);
    check("mid-reset regs", {exp_out, zero, underflow}, 0);
    check("mid-reset mant", mant_out, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check("no result after reset", out_valid, 0);
    end
    run_op(8'd100, mk_mant(20, 1'b1), 0, lat);

    for (int i = 0; i < 6; i++)
      run_op(8'($urandom_range(0, 255)), mk_mant($urandom_range(0, MANT_W - 1), 1'b1), 0, lat);

    check("scoreboard drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
